inst_fetch_ctrl: RTL and testbench
==================================

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the address and instruction data width.
REQ-002 Parameter RESET_PC, default 32'hBFC0_0000, SHALL set the reset value of inst_addr and inst_pc.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 pc_in  in  WIDTH  SHALL carry the current PC from the PC register.
REQ-006 fetch_en  in  1  SHALL be high when the pipeline permits a new fetch.
REQ-007 flush  in  1  SHALL be the redirect (branch/exception): it kills any in-flight or buffered fetch.
REQ-008 de_stall  in  1  SHALL be high when decode cannot accept an instruction this cycle.
REQ-009 inst_req  out  1  SHALL be the instruction-memory request strobe.
REQ-010 inst_addr  out  WIDTH  SHALL be the request address.
REQ-011 inst_addr_ok  in  1  SHALL be the memory request-accept pulse.
REQ-012 inst_data_ok  in  1  SHALL be the memory read-data-valid pulse.
REQ-013 inst_rdata  in  WIDTH  SHALL be the read data, valid only with inst_data_ok.
REQ-014 inst_valid  out  1  SHALL flag that inst_out/inst_pc hold a valid instruction for decode.
REQ-015 inst_out  out  WIDTH  SHALL be the buffered instruction.
REQ-016 inst_pc  out  WIDTH  SHALL be the PC of inst_out.
REQ-017 pc_stall  out  1  SHALL drive the PC register stall input (1 = hold PC).

Function
REQ-018 The FSM SHALL have four states: IDLE, REQ, WAIT, DISCARD.
REQ-019 IDLE -> REQ SHALL occur when fetch_en=1, flush=0, and the buffer is empty or consumed this cycle (inst_valid=0 or de_stall=0); pc_in is latched into inst_addr on that edge.
REQ-020 inst_req SHALL be 1 exactly while in REQ; inst_addr SHALL stay constant while in REQ.
REQ-021 REQ -> WAIT on inst_addr_ok=1 with flush=0; REQ -> DISCARD on inst_addr_ok=1 with flush=1; REQ -> IDLE on flush=1 with inst_addr_ok=0.
REQ-022 WAIT -> IDLE on inst_data_ok=1: with flush=0, inst_rdata -> inst_out, inst_addr -> inst_pc, inst_valid <= 1; with flush=1, data dropped.
REQ-023 WAIT -> DISCARD on flush=1 with inst_data_ok=0.
REQ-024 DISCARD SHALL ignore further flush, drop the next inst_data_ok beat, then go to IDLE.
REQ-025 At most one request SHALL be outstanding; no new request while in WAIT or DISCARD.
REQ-026 inst_valid SHALL clear on a cycle with de_stall=0 and no new capture, and on any flush=1 cycle; a capture takes priority over the consume clear in the same cycle.
REQ-027 pc_stall SHALL be 0 only in the cycle of a successful capture (WAIT, inst_data_ok=1, flush=0) or any flush=1 cycle; otherwise 1.
REQ-028 Steady-state throughput SHALL be one instruction per 3 cycles with 1-cycle addr_ok and data_ok latencies; a data_ok coincident with addr_ok is not permitted.

Reset
REQ-029 On rst_n=0, regardless of clk: state=IDLE, inst_req=0, inst_addr=RESET_PC, inst_valid=0, inst_out=0, inst_pc=RESET_PC; pc_stall=1 follows from IDLE.
REQ-030 A data_ok beat arriving after reset release for a pre-reset request is out of scope; memory is reset with the block.

Verification
REQ-031 Reset then fetch_en=1, pc_in=32'hBFC0_0000, addr_ok and data_ok each 1 cycle after request -> inst_req high 1 cycle with addr 32'hBFC0_0000; inst_valid=1, inst_pc=32'hBFC0_0000, inst_out=rdata; pc_stall=0 in capture cycle only.
REQ-032 addr_ok delayed 4 cycles -> inst_req and inst_addr held stable for all 5 cycles; exactly one capture.
REQ-033 flush in WAIT before data_ok -> DISCARD; following data_ok=32'h2402_0001 not captured, inst_valid stays 0; next request uses the new pc_in.
REQ-034 de_stall=1 for 3 cycles after capture -> inst_valid, inst_out held; no new inst_req until the cycle de_stall falls.
REQ-035 flush coincident with data_ok in WAIT -> data dropped, state IDLE, pc_stall=0 that cycle.
REQ-036 rst_n asserted mid-WAIT -> all outputs at reset values immediately, without a clock edge.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_fetch_ctrl : single-outstanding instruction fetch sequencer with    |
// |                   a one-entry instruction buffer toward decode.          |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module inst_fetch_ctrl #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             fetch_en,
  input  logic             flush,
  input  logic             de_stall,
  output logic             inst_req,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [WIDTH-1:0] inst_rdata,
  output logic             inst_valid,
  output logic [WIDTH-1:0] inst_out,
  output logic [WIDTH-1:0] inst_pc,
  output logic             pc_stall
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             capture;
  logic             launch;

  // A new fetch only starts when the buffer slot is free or drains this cycle.
  always_comb begin
    capture = (state_q == S_WAIT) && inst_data_ok && !flush;
    launch  = (state_q == S_IDLE) && fetch_en && !flush && (!valid_q || !de_stall);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d = S_REQ;
          addr_d  = pc_in;
        end
      end
      S_REQ: begin
        if (inst_addr_ok) begin
          state_d = flush ? S_DISCARD : S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          state_d = S_IDLE;
        end else if (flush) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (inst_data_ok) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture wins over the decode-consume clear; flush wins over both.
  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      out_d   = inst_rdata;
      pc_d    = addr_q;
    end else if (!de_stall) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= RESET_PC;
      valid_q <= 1'b0;
      out_q   <= '0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      pc_q    <= pc_d;
    end
  end

  assign inst_req   = (state_q == S_REQ);
  assign inst_addr  = addr_q;
  assign inst_valid = valid_q;
  assign inst_out   = out_q;
  assign inst_pc    = pc_q;
  assign pc_stall   = !(capture || flush);

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_inst_fetch_ctrl : directed self-checking bench for inst_fetch_ctrl.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_inst_fetch_ctrl;

  localparam int          W   = 32;
  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  pc_in = '0;
  logic          fetch_en = 1'b0;
  logic          flush = 1'b0;
  logic          de_stall = 1'b0;
  logic          inst_req;
  logic [W-1:0]  inst_addr;
  logic          inst_addr_ok = 1'b0;
  logic          inst_data_ok = 1'b0;
  logic [W-1:0]  inst_rdata = '0;
  logic          inst_valid;
  logic [W-1:0]  inst_out;
  logic [W-1:0]  inst_pc;
  logic          pc_stall;

  inst_fetch_ctrl #(.WIDTH(W), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .fetch_en(fetch_en),
    .flush(flush), .de_stall(de_stall), .inst_req(inst_req),
    .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
    .pc_stall(pc_stall)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a pending request, an accepted read that may be
  // marked for dropping, and a one-slot buffer toward decode.
  bit          m_req, m_busy, m_drop, m_valid;
  logic [31:0] m_addr, m_data, m_pc;
  bit          m_was_valid, m_take;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req   = 0;
      m_busy  = 0;
      m_drop  = 0;
      m_valid = 0;
      m_addr  = RPC;
      m_data  = 32'h0;
      m_pc    = RPC;
    end else begin
      m_was_valid = m_valid;
      m_take      = m_busy && inst_data_ok && !m_drop && !flush;
      if (flush) begin
        m_valid = 0;
      end else if (m_take) begin
        m_valid = 1;
        m_data  = inst_rdata;
        m_pc    = m_addr;
      end else if (!de_stall) begin
        m_valid = 0;
      end
      if (m_req) begin
        if (inst_addr_ok) begin
          m_req  = 0;
          m_busy = 1;
          m_drop = flush;
        end else if (flush) begin
          m_req = 0;
        end
      end else if (m_busy) begin
        if (inst_data_ok) begin
          m_busy = 0;
          m_drop = 0;
        end else if (flush) begin
          m_drop = 1;
        end
      end else if (fetch_en && !flush && (!m_was_valid || !de_stall)) begin
        m_req  = 1;
        m_addr = pc_in;
      end
    end
  end

  always @(negedge clk) begin
    chkb("model inst_req", inst_req, m_req);
    chk("model inst_addr", inst_addr, m_addr);
    chkb("model inst_valid", inst_valid, m_valid);
    chk("model inst_out", inst_out, m_data);
    chk("model inst_pc", inst_pc, m_pc);
    chkb("model pc_stall", pc_stall, !(flush || (m_busy && !m_drop && inst_data_ok)));
  end

  task automatic drive(input logic fe, input logic fl, input logic ds, input logic aok,
                       input logic dok, input logic [31:0] pc, input logic [31:0] rd);
    fetch_en     = fe;
    flush        = fl;
    de_stall     = ds;
    inst_addr_ok = aok;
    inst_data_ok = dok;
    pc_in        = pc;
    inst_rdata   = rd;
    #1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, RPC, 0);
    adv(); adv();
    chkb("reset inst_req", inst_req, 1'b0);
    chk("reset inst_addr", inst_addr, RPC);
    chkb("reset inst_valid", inst_valid, 1'b0);
    chk("reset inst_out", inst_out, 32'h0);
    chk("reset inst_pc", inst_pc, RPC);
    chkb("reset pc_stall", pc_stall, 1'b1);
    rst_n = 1'b1;
    adv();

    // Basic fetch, 1-cycle latencies.
    drive(1, 0, 0, 0, 0, 32'hBFC0_0000, 0); adv();
    drive(0, 0, 0, 1, 0, 0, 0);
    chkb("basic req", inst_req, 1'b1);
    chk("basic addr", inst_addr, 32'hBFC0_0000);
    adv();
    drive(0, 0, 1, 0, 1, 0, 32'h3C08_1234);
    chkb("basic capture pc_stall", pc_stall, 1'b0);
    chkb("basic req low in wait", inst_req, 1'b0);
    adv();
    drive(0, 0, 1, 0, 0, 0, 0);
    chkb("basic valid", inst_valid, 1'b1);
    chk("basic out", inst_out, 32'h3C08_1234);
    chk("basic pc", inst_pc, 32'hBFC0_0000);
    chkb("basic pc_stall after", pc_stall, 1'b1);
    adv();

    // addr_ok delayed by 4 cycles.
    drive(1, 0, 0, 0, 0, 32'hBFC0_0004, 0); adv();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 32'hDEAD_0000 + i, 0);
      chkb("delay req held", inst_req, 1'b1);
      chk("delay addr held", inst_addr, 32'hBFC0_0004);
      adv();
    end
    drive(0, 0, 0, 1, 0, 0, 0);
    chkb("delay req last", inst_req, 1'b1);
    adv();
    drive(0, 0, 1, 0, 1, 0, 32'h8C09_0010); adv();
    drive(0, 0, 1, 0, 0, 0, 0);
    chkb("delay valid", inst_valid, 1'b1);
    chk("delay out", inst_out, 32'h8C09_0010);
    chk("delay pc", inst_pc, 32'hBFC0_0004);
    adv();

    // Flush while waiting for data: the late beat is discarded.
    drive(1, 0, 0, 0, 0, 32'hBFC0_0008, 0); adv();
    drive(0, 0, 0, 1, 0, 0, 0); adv();
    drive(0, 1, 0, 0, 0, 0, 0);
    chkb("wait flush pc_stall", pc_stall, 1'b0);
    adv();
    drive(1, 1, 0, 0, 0, 32'h8000_0000, 0); adv();
    drive(0, 0, 0, 0, 1, 0, 32'h2402_0001);
    chkb("discard no capture", pc_stall, 1'b1);
    adv();
    drive(1, 0, 0, 0, 0, 32'h8000_0100, 0);
    chkb("discard valid stays 0", inst_valid, 1'b0);
    chkb("discard no req", inst_req, 1'b0);
    adv();
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("redirect addr", inst_addr, 32'h8000_0100);
    adv();
    drive(0, 0, 1, 0, 1, 0, 32'h2408_0005); adv();
    drive(0, 0, 1, 0, 0, 0, 0);
    chk("redirect out", inst_out, 32'h2408_0005);
    chk("redirect pc", inst_pc, 32'h8000_0100);
    adv();

    // Decode stall holds the buffer and blocks new requests.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0, 0, 32'h8000_0104, 0);
      chkb("stall no req", inst_req, 1'b0);
      chkb("stall valid held", inst_valid, 1'b1);
      chk("stall out held", inst_out, 32'h2408_0005);
      adv();
    end
    drive(1, 0, 0, 0, 0, 32'h8000_0104, 0); adv();
    drive(0, 0, 0, 1, 0, 0, 0);
    chkb("unstall req", inst_req, 1'b1);
    chk("unstall addr", inst_addr, 32'h8000_0104);
    chkb("unstall consumed", inst_valid, 1'b0);
    adv();
    drive(0, 0, 1, 0, 1, 0, 32'h1000_FFFF); adv();

    // Flush coincident with data_ok, then flush in REQ with and without addr_ok.
    drive(1, 0, 0, 0, 0, 32'h8000_0108, 0); adv();
    drive(0, 0, 0, 1, 0, 0, 0); adv();
    drive(0, 1, 0, 0, 1, 0, 32'hAAAA_5555);
    chkb("coinc pc_stall", pc_stall, 1'b0);
    adv();
    drive(1, 0, 0, 0, 0, 32'h8000_010C, 0);
    chkb("coinc valid", inst_valid, 1'b0);
    chkb("coinc idle", inst_req, 1'b0);
    adv();
    drive(0, 1, 0, 0, 0, 0, 0);
    chkb("req before flush", inst_req, 1'b1);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0);
    chkb("req flushed", inst_req, 1'b0);
    adv();
    drive(1, 0, 0, 0, 0, 32'h8000_0200, 0); adv();
    drive(0, 1, 0, 1, 0, 0, 0); adv();
    drive(1, 0, 0, 0, 1, 32'h8000_0300, 32'h1234_5678);
    chkb("req-flush discard no req", inst_req, 1'b0);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0);
    chkb("req-flush valid", inst_valid, 1'b0);
    adv();

    // Back-to-back fetches: one instruction every 3 cycles.
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0, 32'h8000_0400 + 32'(4 * k), 0); adv();
      drive(0, 0, 0, 1, 0, 0, 0); adv();
      drive(0, 0, 0, 0, 1, 0, 32'h0100_0000 + 32'(k)); adv();
    end
    drive(0, 0, 1, 0, 0, 0, 0);
    chk("stream last pc", inst_pc, 32'h8000_0408);
    chk("stream last out", inst_out, 32'h0100_0002);
    adv();

    // Asynchronous reset in WAIT.
    drive(1, 0, 0, 0, 0, 32'h8000_0500, 0); adv();
    drive(0, 0, 0, 1, 0, 0, 0); adv();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chkb("async inst_req", inst_req, 1'b0);
    chk("async inst_addr", inst_addr, RPC);
    chkb("async inst_valid", inst_valid, 1'b0);
    chk("async inst_out", inst_out, 32'h0);
    chk("async inst_pc", inst_pc, RPC);
    chkb("async pc_stall", pc_stall, 1'b1);
    adv();
    rst_n = 1'b1;
    adv();
    drive(1, 0, 0, 0, 0, RPC, 0); adv();
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("post-reset addr", inst_addr, RPC);
    adv();
    drive(0, 0, 0, 0, 1, 0, 32'h0BF0_0123); adv();
    drive(0, 0, 1, 0, 0, 0, 0);
    chk("post-reset out", inst_out, 32'h0BF0_0123);
    adv(); adv();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
